// File: rtl/fetch_ctrl.sv
// Program-counter / flag-register stage feeding the ALU: sequences the PC through
// IDLE/RUN/HALTED, holds the architectural flag and counts retired instructions.
module fetch_ctrl #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned OFF_W = 6,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             halt,
  input  logic             branch_en,
  input  logic [OFF_W-1:0] branch_off,
  input  logic             jump_en,
  input  logic [PC_W-1:0]  jump_target,
  input  logic             flag_we,
  input  logic             alu_flag,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             flag_q,
  output logic             done,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned EXT_W = PC_W - OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PC_W-1:0]  r_pc, w_pc_nxt;
  logic             r_flag, w_flag_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [PC_W-1:0]  w_off_ext;
  logic [CNT_W-1:0] w_cnt_inc;

  // Two's-complement offset widened to PC width; PC math wraps naturally.
  assign w_off_ext = {{EXT_W{branch_off[OFF_W-1]}}, branch_off};
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_flag  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_flag  <= w_flag_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: branch decision uses the flag value from before this edge
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_flag_nxt  = r_flag;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        w_cnt_nxt = w_cnt_inc;
        if (flag_we) w_flag_nxt = alu_flag;
        if (halt) begin
          w_state_nxt = ST_HALTED;
        end else if (jump_en) begin
          w_pc_nxt = jump_target;
        end else if (branch_en && r_flag) begin
          w_pc_nxt = r_pc + w_off_ext;
        end else begin
          w_pc_nxt = r_pc + PC_W'(1);
        end
      end
      default: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = start_addr;
          w_flag_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  assign pc          = r_pc;
  assign flag_q      = r_flag;
  assign instr_cnt   = r_cnt;
  assign fetch_valid = (r_state == ST_RUN);
  assign done        = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: behavioural model checked every cycle plus
// hand-computed expectations for the reset, wrap, branch, priority and counter cases.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, halt, branch_en, jump_en, flag_we, alu_flag;
  logic [9:0] start_addr, jump_target;
  logic [5:0] branch_off;

  logic [9:0]  pc, pc4;
  logic        fetch_valid, flag_q, done, fv4, fq4, done4;
  logic [15:0] instr_cnt;
  logic [3:0]  instr_cnt4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .halt(halt),
    .branch_en(branch_en), .branch_off(branch_off), .jump_en(jump_en),
    .jump_target(jump_target), .flag_we(flag_we), .alu_flag(alu_flag),
    .pc(pc), .fetch_valid(fetch_valid), .flag_q(flag_q), .done(done),
    .instr_cnt(instr_cnt)
  );

  fetch_ctrl #(.PC_W(10), .OFF_W(6), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .halt(halt),
    .branch_en(branch_en), .branch_off(branch_off), .jump_en(jump_en),
    .jump_target(jump_target), .flag_we(flag_we), .alu_flag(alu_flag),
    .pc(pc4), .fetch_valid(fv4), .flag_q(fq4), .done(done4),
    .instr_cnt(instr_cnt4)
  );

  // Behavioural model: plain integers, modulo arithmetic, saturating counts
  int m_pc, m_flag, m_cnt16, m_cnt4, m_off;
  bit m_running, m_halted;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 0; m_flag = 0; m_cnt16 = 0; m_cnt4 = 0;
      m_running = 0; m_halted = 0;
    end else if (m_running) begin
      m_cnt16 = (m_cnt16 + 1 > 65535) ? 65535 : m_cnt16 + 1;
      m_cnt4  = (m_cnt4 + 1 > 15) ? 15 : m_cnt4 + 1;
      m_off   = (int'(branch_off) >= 32) ? int'(branch_off) - 64 : int'(branch_off);
      if (halt) begin
        m_running = 0; m_halted = 1;
      end else if (jump_en) m_pc = int'(jump_target);
      else if (branch_en && m_flag == 1) m_pc = (m_pc + m_off + 1024) % 1024;
      else m_pc = (m_pc + 1) % 1024;
      if (flag_we) m_flag = int'(alu_flag);
    end else if (start) begin
      m_running = 1; m_halted = 0;
      m_pc = int'(start_addr); m_flag = 0; m_cnt16 = 0; m_cnt4 = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    chk("m_pc",    32'(pc),          32'(m_pc));
    chk("m_flag",  32'(flag_q),      32'(m_flag));
    chk("m_valid", 32'(fetch_valid), 32'(m_running));
    chk("m_done",  32'(done),        32'(m_halted));
    chk("m_cnt16", 32'(instr_cnt),   32'(m_cnt16));
    chk("m_cnt4",  32'(instr_cnt4),  32'(m_cnt4));
    chk("m_pc4",   32'(pc4),         32'(m_pc));
    chk("m_done4", 32'(done4),       32'(m_halted));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; halt = 0; branch_en = 0; jump_en = 0; flag_we = 0; alu_flag = 0;
  endtask

  initial begin
    rst_n = 0; idle_in(); start_addr = '0; jump_target = '0; branch_off = '0;
    step(); step();
    rst_n = 1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_valid", 32'(fetch_valid), 32'h0);
    chk("rst_done", 32'(done), 32'h0);

    // Control inputs are ignored in IDLE
    jump_en = 1; jump_target = 10'h123; step(); idle_in();
    chk("idle_hold_pc", 32'(pc), 32'h0);

    // T2 sequential with wrap
    start = 1; start_addr = 10'h3FE; step(); start = 0;
    chk("t2_pc0", 32'(pc), 32'h3FE);
    chk("t2_valid", 32'(fetch_valid), 32'h1);
    step(); chk("t2_pc1", 32'(pc), 32'h3FF);
    step(); chk("t2_pc2", 32'(pc), 32'h000);
    step(); chk("t2_pc3", 32'(pc), 32'h001);
    chk("t2_cnt", 32'(instr_cnt), 32'd3);

    // T3 branch taken / not taken
    jump_en = 1; jump_target = 10'h010; flag_we = 1; alu_flag = 1; step(); idle_in();
    chk("t3_setup_pc", 32'(pc), 32'h010);
    chk("t3_setup_flag", 32'(flag_q), 32'h1);
    branch_en = 1; branch_off = 6'h3C; step(); idle_in();
    chk("t3_taken", 32'(pc), 32'h00C);
    jump_en = 1; jump_target = 10'h010; flag_we = 1; alu_flag = 0; step(); idle_in();
    branch_en = 1; branch_off = 6'h3C; step(); idle_in();
    chk("t3_not_taken", 32'(pc), 32'h011);

    // T4 same-cycle flag write does not steer the branch
    branch_en = 1; branch_off = 6'h3C; flag_we = 1; alu_flag = 1; step(); idle_in();
    chk("t4_pc", 32'(pc), 32'h012);
    chk("t4_flag", 32'(flag_q), 32'h1);
    branch_en = 1; branch_off = 6'h05; step(); idle_in();
    chk("pos_off", 32'(pc), 32'h017);
    jump_en = 1; jump_target = 10'h002; step(); idle_in();
    branch_en = 1; branch_off = 6'h3C; step(); idle_in();
    chk("neg_wrap", 32'(pc), 32'h3FE);

    // T5 start ignored in RUN, halt beats jump, HALTED holds
    start = 1; start_addr = 10'h055; step(); idle_in();
    chk("t5_start_ign", 32'(pc), 32'h3FF);
    jump_en = 1; jump_target = 10'h020; step(); idle_in();
    halt = 1; jump_en = 1; jump_target = 10'h100; step(); idle_in();
    chk("t5_pc", 32'(pc), 32'h020);
    chk("t5_done", 32'(done), 32'h1);
    chk("t5_valid", 32'(fetch_valid), 32'h0);
    jump_en = 1; branch_en = 1; flag_we = 1; alu_flag = 0; step(); idle_in();
    chk("t5_hold_pc", 32'(pc), 32'h020);
    chk("t5_hold_flag", 32'(flag_q), 32'h1);

    // T6 counter saturation on the 4-bit instance; restart clears
    start = 1; start_addr = 10'h100; step(); idle_in();
    chk("t6_restart_flag", 32'(flag_q), 32'h0);
    chk("t6_restart_cnt", 32'(instr_cnt4), 32'h0);
    for (int i = 0; i < 20; i++) step();
    chk("t6_sat4", 32'(instr_cnt4), 32'd15);
    chk("t6_cnt16", 32'(instr_cnt), 32'd20);
    halt = 1; step(); idle_in();
    chk("t6_halt_sat", 32'(instr_cnt4), 32'd15);
    start = 1; start_addr = 10'h000; step(); idle_in();
    chk("t6_clear4", 32'(instr_cnt4), 32'd0);
    chk("t6_clear16", 32'(instr_cnt), 32'd0);

    // T1 asynchronous reset mid-RUN
    jump_en = 1; jump_target = 10'h005; flag_we = 1; alu_flag = 1; step(); idle_in();
    chk("t1_pre_pc", 32'(pc), 32'h005);
    #2 rst_n = 0;
    #1;
    chk("t1_pc", 32'(pc), 32'h0);
    chk("t1_flag", 32'(flag_q), 32'h0);
    chk("t1_valid", 32'(fetch_valid), 32'h0);
    chk("t1_cnt", 32'(instr_cnt), 32'h0);
    step();
    rst_n = 1;
    step();
    chk("t1_idle_pc", 32'(pc), 32'h0);
    chk("t1_idle_valid", 32'(fetch_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
